// File: rtl/spi_cmd_master.sv
// SPI command master: shifts out a variable-length command MSB-first and, for
// read commands (leading 4'b1000), clocks in an inverted reply from the slave.
module spi_cmd_master #(
  parameter int CMD_BIT_NUM   = 41,
  parameter int REPLY_BIT_NUM = 6,
  parameter int CLK_HALF      = 16,
  parameter int CS_GAP        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CMD_BIT_NUM-1:0]   cmd_data,
  input  logic [6:0]               cmd_len,
  output logic                     busy,
  output logic                     done,
  output logic [REPLY_BIT_NUM-1:0] reply,
  output logic                     reply_vld,
  output logic                     spi_clk,
  output logic                     spi_cs,
  output logic                     spi_mosi,
  input  logic                     spi_miso
);

  localparam int DIV_MAX = (CLK_HALF > CS_GAP) ? CLK_HALF : CS_GAP;
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_HALF - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CS_GAP - 1);
  localparam logic [6:0] LEN_MAX  = 7'(CMD_BIT_NUM);
  localparam logic [6:0] RD_TOTAL = 7'(4 + REPLY_BIT_NUM);

  typedef enum logic [2:0] {
    S_IDLE, S_CS_SETUP, S_CLK_LOW, S_CLK_HIGH, S_CS_HOLD, S_CS_IDLE
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [DIV_W-1:0]           r_div;
  logic [6:0]                 r_bit;
  logic [6:0]                 r_total;
  logic                       r_rd;
  logic [CMD_BIT_NUM-1:0]     r_shift;
  logic [REPLY_BIT_NUM-1:0]   r_rx;
  logic [REPLY_BIT_NUM-1:0]   r_reply;
  logic                       r_reply_vld;
  logic                       r_spi_cs;
  logic                       r_spi_clk;
  logic                       r_mosi;
  logic                       r_miso_p1;
  logic                       r_miso_p2;
  logic                       w_accept;
  logic [6:0]                 w_len_eff;
  logic [CMD_BIT_NUM-1:0]     w_shift_in;
  logic                       w_is_rd;
  logic                       w_half_end;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_len_eff  = ((cmd_len == 7'd0) || (cmd_len > LEN_MAX)) ? LEN_MAX : cmd_len;
  // Left-align the command so the first transmitted bit always sits at the top.
  assign w_shift_in = cmd_data << (LEN_MAX - w_len_eff);
  assign w_is_rd    = (w_len_eff >= 7'd4) && (w_shift_in[CMD_BIT_NUM-1 -: 4] == 4'b1000);
  assign w_half_end = (r_div == HALF_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start) w_state_nxt = S_CS_SETUP;
      S_CS_SETUP: if (r_div == GAP_LAST) w_state_nxt = S_CLK_LOW;
      S_CLK_LOW:  if (w_half_end) w_state_nxt = S_CLK_HIGH;
      S_CLK_HIGH: if (w_half_end)
                    w_state_nxt = ((r_bit + 7'd1) == r_total) ? S_CS_HOLD : S_CLK_LOW;
      S_CS_HOLD:  if (w_half_end) w_state_nxt = S_CS_IDLE;
      S_CS_IDLE:  if (r_div == GAP_LAST) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_rd        <= 1'b0;
      r_spi_cs    <= 1'b1;
      r_spi_clk   <= 1'b1;
      r_mosi      <= 1'b0;
      r_reply     <= '0;
      r_reply_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_div     <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? '0 : r_div + 1'b1;
      // SPI pins are registered from the next state so they never glitch.
      r_spi_cs  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_CS_IDLE);
      r_spi_clk <= (w_state_nxt != S_CLK_LOW);
      if (w_accept) begin
        r_bit       <= '0;
        r_rd        <= w_is_rd;
        r_reply_vld <= 1'b0;
      end
      if ((w_state_nxt == S_CLK_LOW) && (r_state != S_CLK_LOW))
        r_mosi <= (r_rd && (r_bit >= 7'd4)) ? 1'b0 : r_shift[CMD_BIT_NUM-1];
      if ((w_state_nxt == S_CS_HOLD) && (r_state != S_CS_HOLD))
        r_mosi <= 1'b0;
      if ((r_state == S_CLK_HIGH) && w_half_end)
        r_bit <= r_bit + 7'd1;
      if ((r_state == S_CS_HOLD) && (w_state_nxt == S_CS_IDLE)) begin
        r_reply_vld <= r_rd;
        if (r_rd)
          r_reply <= ~r_rx;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_miso_p1 <= spi_miso;
    r_miso_p2 <= r_miso_p1;
    if (w_accept) begin
      r_shift <= w_shift_in;
      r_total <= w_is_rd ? RD_TOTAL : w_len_eff;
    end else if ((w_state_nxt == S_CLK_LOW) && (r_state != S_CLK_LOW)) begin
      r_shift <= r_shift << 1;
    end
    if ((r_state == S_CLK_HIGH) && w_half_end && r_rd && (r_bit >= 7'd4))
      r_rx <= {r_rx[REPLY_BIT_NUM-2:0], r_miso_p2};
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_CS_IDLE) && (r_div == GAP_LAST);
  assign reply     = r_reply;
  assign reply_vld = r_reply_vld;
  assign spi_clk   = r_spi_clk;
  assign spi_cs    = r_spi_cs;
  assign spi_mosi  = r_mosi;

endmodule
